arilla_bus_initiator: RTL and testbench

- Single-outstanding initiator on arilla_bus. Turns a byte-addressed load/store request (valid/ready) into one read or write strobe on the bus.
- Returns aligned, extended read data on a response handshake.
- Targets bus responders such as on-chip RAM: one-cycle read latency, tri-state data_ptc. Used by the debug module's system-bus-access path and by test masters.

---
 rtl/arilla_bus_initiator_if.sv | 23 ++
 rtl/arilla_bus_initiator.sv | 182 ++++++++++++++++++
 tb/tb_arilla_bus_initiator.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arilla_bus_initiator_if.sv
// rtl/arilla_bus_initiator_if.sv - arilla_bus signal bundle shared by initiators and responders
interface arilla_bus_if #(
  parameter int AddressWidth = 30,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0] address;
  logic [3:0]              byte_enable;
  logic [DataWidth-1:0]    data_ctp;
  logic                    read;
  logic                    write;
  wire  [DataWidth-1:0]    data_ptc;
  logic                    intercept;

  modport initiator (
    output address, byte_enable, data_ctp, read, write,
    input  data_ptc
  );

  modport responder (
    input  address, byte_enable, data_ctp, read, write,
    output data_ptc, intercept
  );
endinterface

// File: rtl/arilla_bus_initiator.sv
// rtl/arilla_bus_initiator.sv - single-outstanding load/store initiator for arilla_bus
// Optional feature macro: ARILLA_BUS_INITIATOR_AUTOINC_EN (auto-incrementing address register)
module arilla_bus_initiator #(
  parameter int ByteAddressWidth = 32,
  parameter int DataWidth        = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ByteAddressWidth-1:0] req_addr,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [DataWidth-1:0]        req_wdata,
`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
  input  logic                        req_autoinc,
`endif
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DataWidth-1:0]        rsp_rdata,
  output logic                        rsp_error,
  arilla_bus_if.initiator             bus_interface
);

  if (DataWidth != $bits(bus_interface.data_ctp)) begin : g_width_check
    $error("arilla_bus_initiator: DataWidth does not match bus data width");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t                      state_q;
  state_t                      state_d;

  logic                        write_q;
  logic [ByteAddressWidth-1:0] addr_q;
  logic [1:0]                  size_q;
  logic                        unsigned_q;
  logic [DataWidth-1:0]        wdata_q;
  logic [DataWidth-1:0]        rdata_q;
  logic                        error_q;

  logic                        accept;
  logic [ByteAddressWidth-1:0] eff_addr;
  logic                        req_err;
  logic [DataWidth-1:0]        shifted;
  logic [DataWidth-1:0]        load_ext;

  assign accept = req_valid && req_ready;

`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
  assign eff_addr = req_autoinc ? addr_q : req_addr;
`else
  assign eff_addr = req_addr;
`endif

  // Reserved size and misaligned half/word accesses are rejected without touching the bus
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd1:    req_err = eff_addr[0];
      2'd2:    req_err = |eff_addr[1:0];
      2'd3:    req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Align the returned bus word to the requested lane, then mask and extend to size
  always_comb begin
    shifted  = bus_interface.data_ptc >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0:    load_ext = {{(DataWidth-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = {{(DataWidth-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and outputs; bus strobes depend only on registered state and fields
  always_comb begin
    state_d                   = state_q;
    req_ready                 = 1'b0;
    rsp_valid                 = 1'b0;
    bus_interface.address     = '0;
    bus_interface.byte_enable = 4'b0000;
    bus_interface.data_ctp    = '0;
    bus_interface.read        = 1'b0;
    bus_interface.write       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        bus_interface.address = addr_q[ByteAddressWidth-1:2];
        case (size_q)
          2'd0: begin
            bus_interface.byte_enable = 4'b0001 << addr_q[1:0];
            bus_interface.data_ctp    = {4{wdata_q[7:0]}};
          end
          2'd1: begin
            bus_interface.byte_enable = 4'b0011 << addr_q[1:0];
            bus_interface.data_ctp    = {2{wdata_q[15:0]}};
          end
          default: begin
            bus_interface.byte_enable = 4'b1111;
            bus_interface.data_ctp    = wdata_q;
          end
        endcase
        bus_interface.read  = ~write_q;
        bus_interface.write = write_q;
        state_d = write_q ? S_RESP : S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, load-data capture and response holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      if (accept) begin
        write_q    <= req_write;
        addr_q     <= eff_addr;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
        rdata_q    <= '0;
        error_q    <= req_err;
      end
      if (state_q == S_CAPTURE) begin
        rdata_q <= load_ext;
      end
`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
      // Advance only after the lane offset is no longer needed by this access
      if ((state_q == S_ACCESS && write_q) || state_q == S_CAPTURE) begin
        addr_q <= addr_q + (ByteAddressWidth'(1) << size_q);
      end
`endif
      if (state_q == S_RESP && rsp_ready) begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_arilla_bus_initiator.sv
// tb/tb_arilla_bus_initiator.sv - directed self-checking bench for arilla_bus_initiator
module tb_arilla_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
  logic        req_autoinc;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] ptc_drv;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arilla_bus_if #(.AddressWidth(30), .DataWidth(32)) bus ();
  assign bus.data_ptc  = ptc_drv;
  assign bus.intercept = 1'b0;

  arilla_bus_initiator #(.ByteAddressWidth(32), .DataWidth(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
    .req_autoinc  (req_autoinc),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .bus_interface(bus)
  );

  // Present one request and return just after the accepting edge (start of cycle 1)
  task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s,
                      input logic u, input logic [31:0] d, input logic ai);
    @(posedge clk); #1;
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_size     = s;
    req_unsigned = u;
    req_wdata    = d;
`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
    req_autoinc  = ai;
`else
    if (ai) req_wdata = d;
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got %h/%b want 0/0", rsp_rdata, rsp_error); end
    n_cmp++; if ({bus.read, bus.write, bus.byte_enable} !== 6'b0 || bus.address !== 30'h0 || bus.data_ctp !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus got r%b w%b be%b a%h d%h want all 0", bus.read, bus.write, bus.byte_enable, bus.address, bus.data_ctp);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_store;
    send(1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    n_cmp++; if ({bus.write, bus.read} !== 2'b10) begin n_fail++; $display("FAIL wstore_strobe got w%b r%b want w1 r0", bus.write, bus.read); end
    n_cmp++; if (bus.address !== 30'h4) begin n_fail++; $display("FAIL wstore_addr got %h want 4", bus.address); end
    n_cmp++; if (bus.byte_enable !== 4'b1111) begin n_fail++; $display("FAIL wstore_be got %b want 1111", bus.byte_enable); end
    n_cmp++; if (bus.data_ctp !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wstore_data got %h want deadbeef", bus.data_ctp); end
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL wstore_c1_hs got v%b rdy%b want 0/0", rsp_valid, req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL wstore_rsp got v%b e%b d%h want 1/0/0", rsp_valid, rsp_error, rsp_rdata);
    end
    n_cmp++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL wstore_single_strobe got %b want 0", bus.write); end
  endtask

  task automatic test_half_store;
    send(1'b1, 32'h0000_0012, 2'd1, 1'b0, 32'h0000_A5C3, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.byte_enable !== 4'b1100) begin n_fail++; $display("FAIL hstore_be got %b want 1100", bus.byte_enable); end
    n_cmp++; if (bus.data_ctp !== 32'hA5C3_A5C3) begin n_fail++; $display("FAIL hstore_data got %h want a5c3a5c3", bus.data_ctp); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hstore_rsp got %b want 1", rsp_valid); end
  endtask

  task automatic test_loads;
    logic [31:0] t_addr [6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h08, 32'h01};
    logic [1:0]  t_size [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    logic        t_uns  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_ptc  [6] = '{32'h80FF_1234, 32'h80FF_1234, 32'hA5C3_0000, 32'hA5C3_0000, 32'hCAFE_F00D, 32'h0000_7F00};
    logic [3:0]  t_be   [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0010};
    logic [29:0] t_wa   [6] = '{30'h4, 30'h4, 30'h4, 30'h4, 30'h2, 30'h0};
    logic [31:0] t_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_A5C3, 32'hFFFF_A5C3, 32'hCAFE_F00D, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      send(1'b0, t_addr[i], t_size[i], t_uns[i], 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      n_cmp++; if ({bus.read, bus.write} !== 2'b10 || bus.byte_enable !== t_be[i] || bus.address !== t_wa[i]) begin
        n_fail++; $display("FAIL load%0d_strobe got r%b w%b be%b a%h want r1 w0 be%b a%h", i, bus.read, bus.write, bus.byte_enable, bus.address, t_be[i], t_wa[i]);
      end
      ptc_drv = t_ptc[i];
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0 || bus.read !== 1'b0) begin n_fail++; $display("FAIL load%0d_c2 got v%b r%b want 0/0", i, rsp_valid, bus.read); end
      @(negedge clk);
      ptc_drv = 32'h0;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== t_exp[i]) begin
        n_fail++; $display("FAIL load%0d_rsp got v%b e%b d%h want 1/0/%h", i, rsp_valid, rsp_error, rsp_rdata, t_exp[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] e_addr  [3] = '{32'h02, 32'h00, 32'h13};
    logic [1:0]  e_size  [3] = '{2'd2, 2'd3, 2'd1};
    logic        e_write [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(e_write[i], e_addr[i], e_size[i], 1'b0, 32'h1234_5678, 1'b0);
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin
        n_fail++; $display("FAIL err%0d_rsp got v%b e%b d%h want 1/1/0", i, rsp_valid, rsp_error, rsp_rdata);
      end
      n_cmp++; if ({bus.read, bus.write} !== 2'b00 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL err%0d_nostrobe got r%b w%b rdy%b want 0/0/0", i, bus.read, bus.write, req_ready);
      end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0 || {bus.read, bus.write} !== 2'b00) begin
        n_fail++; $display("FAIL err%0d_after got v%b r%b w%b want 0/0/0", i, rsp_valid, bus.read, bus.write);
      end
    end
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b0;
    send(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    ptc_drv = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    ptc_drv = 32'h0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_size = 2'd2; req_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_error !== 1'b0) begin
        n_fail++; $display("FAIL hold%0d_rsp got v%b d%h e%b want 1/12345678/0", i, rsp_valid, rsp_rdata, rsp_error);
      end
      n_cmp++; if (req_ready !== 1'b0 || {bus.read, bus.write} !== 2'b00) begin
        n_fail++; $display("FAIL hold%0d_block got rdy%b r%b w%b want 0/0/0", i, req_ready, bus.read, bus.write);
      end
      if (i == 4) begin rsp_ready = 1'b1; req_valid = 1'b0; end
      @(negedge clk);
    end
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || bus.write !== 1'b0) begin
      n_fail++; $display("FAIL hold_release got v%b rdy%b w%b want 0/1/0", rsp_valid, req_ready, bus.write);
    end
  endtask

  task automatic test_reset_mid;
    send(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.read !== 1'b1) begin n_fail++; $display("FAIL rstacc_pre got r%b want 1", bus.read); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.read !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstacc_drop got r%b rdy%b v%b want 0/1/0", bus.read, req_ready, rsp_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    send(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #2;
    ptc_drv = 32'h0BAD_0BAD;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || {bus.read, bus.write} !== 2'b00) begin
      n_fail++; $display("FAIL rstcap_drop got v%b rdy%b r%b w%b want 0/1/0/0", rsp_valid, req_ready, bus.read, bus.write);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    ptc_drv = 32'h0;
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rstcap_discard got v%b d%h want 0/0", rsp_valid, rsp_rdata);
    end
  endtask

`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
  task automatic test_autoinc;
    send(1'b1, 32'h0000_0100, 2'd2, 1'b0, 32'h1111_1111, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.address !== 30'h40) begin n_fail++; $display("FAIL ainc_store got %h want 40", bus.address); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 32'h0000_0FFC, 2'd2, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      n_cmp++; if (bus.address !== 30'h41 + 30'(i)) begin n_fail++; $display("FAIL ainc_load%0d got %h want %h", i, bus.address, 30'h41 + 30'(i)); end
      @(negedge clk); @(negedge clk);
    end
    send(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.address !== 30'h44 || bus.byte_enable !== 4'b0001) begin
      n_fail++; $display("FAIL ainc_byte got a%h be%b want 44/0001", bus.address, bus.byte_enable);
    end
    @(negedge clk); @(negedge clk);
    send(1'b0, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    n_cmp++; if (rsp_error !== 1'b1) begin n_fail++; $display("FAIL ainc_err got %b want 1", rsp_error); end
    @(negedge clk);
    send(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.address !== 30'h44 || bus.byte_enable !== 4'b0010) begin
      n_fail++; $display("FAIL ainc_noinc got a%h be%b want 44/0010", bus.address, bus.byte_enable);
    end
    @(negedge clk); @(negedge clk);
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
    req_autoinc  = 1'b0;
`endif
    rsp_ready    = 1'b1;
    ptc_drv      = 32'h0;
    test_reset();
    test_word_store();
    test_loads();
    test_half_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef ARILLA_BUS_INITIATOR_AUTOINC_EN
    test_autoinc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
